// File: rtl/enemy_bullet_field.sv
// Enemy bullet engine: per-lane shift fields driven by a step divider,
// with fire injection, bullet cancel, and player hit/lives tracking.
module enemy_bullet_field #(
  parameter int LANES    = 8,
  parameter int LANE_W   = 3,
  parameter int ROWS     = 120,
  parameter int ROW_W    = 7,
  parameter int STEP_DIV = 833333,
  parameter int LIVES    = 3,
  parameter int LIFE_W   = 2,
  parameter int INVULN   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fire_valid,
  input  logic [LANE_W-1:0]     fire_lane,
  output logic                  fire_ready,
  input  logic                  cancel_valid,
  input  logic [LANE_W-1:0]     cancel_lane,
  input  logic [ROW_W-1:0]      cancel_row,
  input  logic [LANE_W-1:0]     player_lane,
  output logic [LANES*ROWS-1:0] bullets,
  output logic                  step_pulse,
  output logic                  hit_pulse,
  output logic [LIFE_W-1:0]     lives,
  output logic                  game_over
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int INV_W = (INVULN > 0) ? $clog2(INVULN + 1) : 1;

  logic [LANES*ROWS-1:0] bits_q, bits_d;
  logic [LANES*ROWS-1:0] cmask, pre;
  logic [LANES-1:0]      pend_q, pend_d;
  logic [LANES-1:0]      fire_oh;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [LIFE_W-1:0]     lives_q, lives_d;
  logic [INV_W-1:0]      inv_q, inv_d;
  logic                  hit_q, hit_d;
  logic                  run, step, arrive, pend_sel, hit;

  assign game_over  = (lives_q == '0);
  assign run        = enable & ~game_over;
  assign step       = run & (div_q == '0);
  assign step_pulse = step;
  assign fire_ready = ~pend_sel & ~game_over;
  assign bullets    = bits_q;
  assign lives      = lives_q;
  assign hit_pulse  = hit_q;

  always_comb begin
    cmask    = '0;
    fire_oh  = '0;
    pend_sel = 1'b0;
    arrive   = 1'b0;
    // Matching by loop keeps out-of-range lanes/rows naturally ignored
    for (int l = 0; l < LANES; l++) begin
      if (fire_lane == LANE_W'(l)) begin
        fire_oh[l] = 1'b1;
        pend_sel   = pend_q[l];
      end
      for (int r = 0; r < ROWS; r++) begin
        if (cancel_valid && !game_over &&
            cancel_lane == LANE_W'(l) &&
            cancel_row == ROW_W'(r))
          cmask[l*ROWS+r] = 1'b1;
      end
    end
    pre = bits_q & ~cmask;
    for (int l = 0; l < LANES; l++) begin
      if (player_lane == LANE_W'(l))
        arrive = pre[l*ROWS+ROWS-1];
    end
    hit = step & arrive & (inv_q == '0);

    bits_d = pre;
    pend_d = pend_q;
    if (step) begin
      pend_d = '0;
      for (int l = 0; l < LANES; l++) begin
        bits_d[l*ROWS] = pend_q[l];
        for (int r = 1; r < ROWS; r++)
          bits_d[l*ROWS+r] = pre[l*ROWS+r-1];
      end
    end
    if (fire_valid && fire_ready)
      pend_d = pend_d | fire_oh;

    div_d = div_q;
    if (run)
      div_d = (div_q == '0) ? DIV_W'(STEP_DIV - 1)
                            : div_q - DIV_W'(1);

    inv_d   = inv_q;
    lives_d = lives_q;
    if (hit) begin
      inv_d   = INV_W'(INVULN);
      lives_d = lives_q - LIFE_W'(1);
    end else if (step && inv_q != '0) begin
      inv_d = inv_q - INV_W'(1);
    end
    hit_d = hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bits_q  <= '0;
      pend_q  <= '0;
      div_q   <= DIV_W'(STEP_DIV - 1);
      lives_q <= LIFE_W'(LIVES);
      inv_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      lives_q <= lives_d;
      inv_q   <= inv_d;
      hit_q   <= hit_d;
    end
  end

endmodule

// File: tb/tb_enemy_bullet_field.sv
// Randomized scoreboard bench for enemy_bullet_field against a
// bullet-list reference model.
module tb_enemy_bullet_field;

  localparam int LANES    = 8;
  localparam int LANE_W   = 3;
  localparam int ROWS     = 4;
  localparam int ROW_W    = 2;
  localparam int STEP_DIV = 2;
  localparam int LIVES    = 3;
  localparam int LIFE_W   = 2;
  localparam int INVULN   = 2;
  localparam int NB       = LANES * ROWS;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              fire_valid = 1'b0;
  logic [LANE_W-1:0] fire_lane = '0;
  logic              fire_ready;
  logic              cancel_valid = 1'b0;
  logic [LANE_W-1:0] cancel_lane = '0;
  logic [ROW_W-1:0]  cancel_row = '0;
  logic [LANE_W-1:0] player_lane = '0;
  logic [NB-1:0]     bullets;
  logic              step_pulse;
  logic              hit_pulse;
  logic [LIFE_W-1:0] lives;
  logic              game_over;

  enemy_bullet_field #(
    .LANES(LANES), .LANE_W(LANE_W), .ROWS(ROWS), .ROW_W(ROW_W),
    .STEP_DIV(STEP_DIV), .LIVES(LIVES), .LIFE_W(LIFE_W),
    .INVULN(INVULN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .fire_valid(fire_valid), .fire_lane(fire_lane),
    .fire_ready(fire_ready), .cancel_valid(cancel_valid),
    .cancel_lane(cancel_lane), .cancel_row(cancel_row),
    .player_lane(player_lane), .bullets(bullets),
    .step_pulse(step_pulse), .hit_pulse(hit_pulse),
    .lives(lives), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct { int lane; int row; } blt_t;
  typedef struct {
    logic          sp, fr, hp, go;
    logic [1:0]    lv;
    logic [NB-1:0] bl;
  } exp_t;

  blt_t field[$];
  exp_t sb[$];
  bit   pend[LANES];
  int   m_lives, m_inv, m_cnt;
  bit   m_hit;
  int   total = 0;
  int   bad = 0;
  bit   done = 0;

  function automatic void m_reset();
    field.delete();
    foreach (pend[i]) pend[i] = 0;
    m_lives = LIVES;
    m_inv   = 0;
    m_cnt   = 0;
    m_hit   = 0;
  endfunction

  function automatic bit m_step(bit en);
    return en && m_lives != 0 && (m_cnt % STEP_DIV) == STEP_DIV - 1;
  endfunction

  function automatic bit m_ready(int fl);
    return m_lives != 0 && !pend[fl];
  endfunction

  function automatic exp_t m_outputs(bit en, int fl);
    exp_t e;
    e.bl = '0;
    foreach (field[i]) e.bl[field[i].lane*ROWS + field[i].row] = 1'b1;
    e.sp = m_step(en);
    e.fr = m_ready(fl);
    e.hp = m_hit;
    e.lv = 2'(m_lives);
    e.go = (m_lives == 0);
    return e;
  endfunction

  function automatic void m_advance(bit en, bit fv, int fl, bit cv,
                                    int cl, int cr, int pl);
    bit   go  = (m_lives == 0);
    bit   st  = m_step(en);
    bit   rdy = m_ready(fl);
    bit   arrived = 0;
    bit   hitnow;
    blt_t nf[$];
    if (cv && !go)
      for (int i = field.size() - 1; i >= 0; i--)
        if (field[i].lane == cl && field[i].row == cr) field.delete(i);
    if (st) begin
      foreach (field[i]) begin
        if (field[i].row == ROWS - 1) begin
          if (field[i].lane == pl) arrived = 1;
        end else begin
          nf.push_back('{field[i].lane, field[i].row + 1});
        end
      end
      for (int l = 0; l < LANES; l++)
        if (pend[l]) begin
          nf.push_back('{l, 0});
          pend[l] = 0;
        end
      field = nf;
    end
    hitnow = st && arrived && m_inv == 0;
    m_hit  = hitnow;
    if (hitnow) begin
      m_lives--;
      m_inv = INVULN;
    end else if (st && m_inv > 0) begin
      m_inv--;
    end
    if (en && !go) m_cnt++;
    if (fv && rdy) pend[fl] = 1;
  endfunction

  task automatic cyc(input bit rst, input bit en, input bit fv,
                     input int fl, input bit cv, input int cl,
                     input int cr, input int pl);
    @(negedge clock);
    reset_n      = !rst;
    enable       = en;
    fire_valid   = fv;
    fire_lane    = LANE_W'(fl);
    cancel_valid = cv;
    cancel_lane  = LANE_W'(cl);
    cancel_row   = ROW_W'(cr);
    player_lane  = LANE_W'(pl);
    if (rst) m_reset();
    sb.push_back(m_outputs(en, fl));
    if (!rst) m_advance(en, fv, fl, cv, cl, cr, pl);
  endtask

  task automatic idle(input int n, input int pl);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0, pl);
  endtask

  task automatic rand_cycles(input int n, input bit aim_fire);
    int pl = $urandom_range(0, LANES - 1);
    for (int i = 0; i < n; i++) begin
      bit en = ($urandom % 8) != 0;
      bit fv = ($urandom % 3) == 0;
      int fl = aim_fire ? pl : $urandom_range(0, LANES - 1);
      bit cv = ($urandom % 4) == 0;
      int cl = $urandom_range(0, LANES - 1);
      int cr = $urandom_range(0, ROWS - 1);
      if (cv && field.size() > 0 && ($urandom % 2)) begin
        int k = $urandom_range(0, field.size() - 1);
        cl = field[k].lane;
        cr = field[k].row;
      end
      if (($urandom % 16) == 0) pl = $urandom_range(0, LANES - 1);
      cyc(0, en, fv, fl, cv, cl, cr, pl);
    end
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] got,
                     input logic [NB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic driver();
    m_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 5);
    cyc(1, 1, 0, 0, 0, 0, 0, 5);
    cyc(0, 1, 1, 2, 0, 0, 0, 5);
    idle(14, 5);
    cyc(0, 1, 1, 5, 0, 0, 0, 5);
    idle(2, 5);
    cyc(0, 1, 1, 5, 0, 0, 0, 5);
    idle(14, 5);
    cyc(0, 1, 1, 3, 0, 0, 0, 5);
    cyc(0, 1, 1, 3, 0, 0, 0, 5);
    idle(3, 5);
    cyc(0, 1, 1, 3, 0, 0, 0, 5);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, i, 0, 0, 0, 0);
    idle(3, 0);
    cyc(0, 1, 0, 0, 1, 5, 1, 0);
    cyc(0, 1, 0, 0, 1, 5, 1, 0);
    idle(10, 0);
    for (int k = 0; k < 4; k++) begin
      rand_cycles(150, k[0]);
      cyc(1, 1, 1, 1, 1, 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 5, 0, 0, 0, 5);
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 2, 0, 0, 0, 5);
    for (int i = 0; i < 80; i++) cyc(0, 1, 1, 6, 0, 0, 0, 6);
    rand_cycles(40, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    rand_cycles(100, 0);
    done = 1;
  endtask

  task automatic monitor();
    int guard = 0;
    exp_t e;
    while (!(done && sb.size() == 0)) begin
      @(negedge clock);
      #2;
      guard++;
      if (guard > 50000) begin
        bad++;
        $display("FAIL monitor_timeout got=%0d exp=0", sb.size());
        break;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bullets", bullets, e.bl);
        chk("step_pulse", NB'(step_pulse), NB'(e.sp));
        chk("fire_ready", NB'(fire_ready), NB'(e.fr));
        chk("hit_pulse", NB'(hit_pulse), NB'(e.hp));
        chk("lives", NB'(lives), NB'(e.lv));
        chk("game_over", NB'(game_over), NB'(e.go));
      end
    end
  endtask

  initial begin
    fork
      driver();
      monitor();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
